axis_fifo_wr_arbiter: RTL



---
 rtl/axis_fifo_wr_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/axis_fifo_wr_arbiter.sv
// rtl/axis_fifo_wr_arbiter.sv - packet-aware round-robin arbiter feeding an async FIFO write port
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module axis_fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_s_tvalid,
  output logic [NUM_REQ-1:0]           o_s_tready,
  input  logic [NUM_REQ*DATA_W-1:0]    i_s_tdata,
  input  logic [NUM_REQ-1:0]           i_s_tlast,
  output logic                         o_wr,
  output logic [DATA_W:0]              o_wdata,
  input  logic                         i_wfull,
  output logic                         o_grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   o_grant_idx,
  output logic                         o_timeout
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]   r_grant_idx, w_grant_idx_nxt;
  logic            r_grant_valid, w_grant_valid_nxt;
  logic [IW-1:0]   w_sel_idx;
  logic [IW-1:0]   w_ptr_inc;
  logic            w_any;
  logic            w_g_valid;
  logic            w_g_last;
  logic [DATA_W-1:0] w_g_data;
  logic            w_xfer;

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   r_stall_cnt, w_stall_cnt_nxt;
  logic            r_timeout, w_timeout_nxt;
`endif

  assign w_g_valid = i_s_tvalid[r_grant_idx];
  assign w_g_last  = i_s_tlast[r_grant_idx];
  assign w_g_data  = i_s_tdata[r_grant_idx*DATA_W +: DATA_W];
  assign w_xfer    = (r_state == S_GRANT) && w_g_valid && !i_wfull;
  assign w_ptr_inc = (r_grant_idx == IW'(NUM_REQ - 1)) ? '0 : r_grant_idx + IW'(1);

  // Walk downward so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    int k;
    k         = 0;
    w_sel_idx = '0;
    w_any     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (i_s_tvalid[IW'(k)]) begin
        w_sel_idx = IW'(k);
        w_any     = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_idx_nxt   = r_grant_idx;
    w_grant_valid_nxt = r_grant_valid;
    o_s_tready        = '0;
    o_wr              = 1'b0;
    o_wdata           = '0;
`ifdef ARB_WATCHDOG_EN
    w_stall_cnt_nxt   = r_stall_cnt;
    w_timeout_nxt     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_idx_nxt   = w_sel_idx;
          w_grant_valid_nxt = 1'b1;
          w_state_nxt       = S_GRANT;
`ifdef ARB_WATCHDOG_EN
          w_stall_cnt_nxt   = '0;
`endif
        end
      end
      S_GRANT: begin
        o_s_tready[r_grant_idx] = !i_wfull;
        o_wr                    = w_xfer;
        if (w_xfer) begin
          o_wdata = {w_g_last, w_g_data};
`ifdef ARB_WATCHDOG_EN
          w_stall_cnt_nxt = '0;
`endif
          if (w_g_last) begin
            w_state_nxt       = S_IDLE;
            w_rr_ptr_nxt      = w_ptr_inc;
            w_grant_valid_nxt = 1'b0;
          end
        end
`ifdef ARB_WATCHDOG_EN
        // Only a silent source counts as stalled; backpressure from the FIFO does not.
        else if (!w_g_valid) begin
          if (r_stall_cnt == CW'(TIMEOUT - 1)) begin
            w_state_nxt       = S_IDLE;
            w_rr_ptr_nxt      = w_ptr_inc;
            w_grant_valid_nxt = 1'b0;
            w_timeout_nxt     = 1'b1;
            w_stall_cnt_nxt   = '0;
          end else begin
            w_stall_cnt_nxt = r_stall_cnt + CW'(1);
          end
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      r_stall_cnt   <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_grant_valid <= w_grant_valid_nxt;
`ifdef ARB_WATCHDOG_EN
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
`endif
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_idx   = r_grant_idx;
`ifdef ARB_WATCHDOG_EN
  assign o_timeout     = r_timeout;
`else
  assign o_timeout     = 1'b0;
`endif

endmodule
